square_freq_sweep: RTL and testbench
====================================

# square_freq_sweep

Upstream timing stage for pulse channel 1. Divides the system clock by the programmed 11-bit channel frequency and emits a one-cycle `step` strobe. That strobe advances the 8-step duty sequencer immediately downstream. Also implements the channel-1 frequency sweep and its overflow-disable.

## Interface
Parameters:
- `PRESCALE`, default 4: system clocks per timer decrement.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `trigger`, in, 1: one-cycle channel (re)start strobe.
- `freq_wr`, in, 1: one-cycle load of `freq_in` into the active frequency only.
- `freq_in`, in, 11: programmed frequency, 0..2047.
- `sweep_period`, in, 3: sweep period in sweep ticks; 0 means "reload as 8, no update".
- `sweep_negate`, in, 1: 1 = subtract, 0 = add.
- `sweep_shift`, in, 3: shift amount for the sweep delta.
- `sweep_tick`, in, 1: one-cycle 128 Hz strobe from the frame sequencer.
- `step`, out, 1: one-cycle strobe to the duty sequencer.
- `freq_out`, out, 11: active frequency.
- `channel_off`, out, 1: channel disabled by sweep overflow or not yet triggered.

## Operation
Reset values:
- `step`=0, `freq_out`=0, `channel_off`=1.
- Shadow=0, timer=0, prescaler=0, sweep timer=0, sweep enable=0.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- Produces an internal tick on the cycle it holds PRESCALE-1.

Period timer:
- 12-bit down counter.
- On each prescale tick:
  - If timer==1: reload to 2048−`freq_out` and assert `step` next cycle.
  - Otherwise: decrement.
- Reload range is 1 (freq 2047) to 2048 (freq 0). Width is 12 bits, so no overflow.

Trigger (highest priority that cycle):
- Shadow and `freq_out` load `freq_in`.
- Timer loads 2048−`freq_in`; prescaler clears to 0.
- Sweep timer loads `sweep_period`, with 0 loaded as 8.
- Sweep enable = (`sweep_period`≠0) or (`sweep_shift`≠0).
- `channel_off` clears.
- If `sweep_shift`≠0, run an overflow check on `freq_in`. If it overflows, `channel_off`=1.
- Pending `step`, prescale tick and `sweep_tick` in that cycle are discarded.

Sweep calculation:
- new = shadow ± (shadow >> `sweep_shift`), computed 12-bit.
- Overflow means new > 2047.
- Subtract cannot underflow.
- Add with shift 0 doubles the shadow value.

Sweep tick, when sweep timer ≠0:
- Decrement the sweep timer.
- When it reaches 0, reload it (period 0 reloads as 8).
- If sweep enable and `sweep_period`≠0, compute new:
  - If new overflows: `channel_off`=1.
  - Else if `sweep_shift`≠0: shadow and `freq_out` take new. Then recompute from new; if that second value overflows, `channel_off`=1 in the same cycle.

Channel off:
- While `channel_off`=1: `step` is held 0, and timer and prescaler freeze.
- Sweep register writes are suppressed.
- Only `trigger` or reset clears `channel_off`.

Write collisions:
- `freq_wr` without trigger updates `freq_out` only; the shadow is unchanged.
- `freq_wr` in the same cycle as a sweep write: `freq_wr` wins for `freq_out`, the shadow takes the sweep value.

## Timing
- `step` is registered and goes high on the cycle after the prescale tick that reloads the timer.
- Steady-state period is (2048−f)·PRESCALE clocks.
- First `step` after trigger: exactly (2048−f)·PRESCALE clocks after the trigger cycle.
- Sweep results appear on `freq_out` and `channel_off` the cycle after `sweep_tick`.
- A new `freq_out` takes effect at the next timer reload, not mid-count.
- Reset mid-operation asynchronously forces all reset values. The first `clk` edge after deassertion performs no sweep or step.

## Structure
- Package `gb_sound_pkg` holds:
  - `FREQ_W`=11
  - `FREQ_MAX`=2047
  - `PERIOD_BASE`=2048
  - `SWEEP_ZERO_RELOAD`=8
  - typedef `freq_t` (11-bit)
- Sub-module `sweep_unit` holds the sweep timer, shadow, enable, and the calculate/overflow logic. It outputs the write strobe, the new frequency and the overflow flag.
- The prescaler and period timer stay in the top module.

## Test plan
- Trigger f=2047, PRESCALE=4 → first `step` 4 clks after trigger, then every 4 clks, each exactly 1 clk wide.
- Trigger f=0 → `step` period 8192 clks. A `freq_wr` of 2046 mid-count → next period after reload is 8 clks.
- Trigger f=1024, period=1, shift=1, add; one `sweep_tick` → `freq_out`=1536, then second check 2304 → `channel_off`=1, `step` stops.
- Trigger f=1400, shift=1, add → `channel_off`=1 the cycle after trigger, and no `step` ever.
- Trigger f=1024, period=2, shift=2, negate; two `sweep_tick`s → `freq_out`=768 after the second tick only.
- Free-running at f=2040, assert `rst_n`=0 asynchronously mid-count → `step`=0, `freq_out`=0, `channel_off`=1 immediately. Release, then trigger → normal operation resumes.

Source files
------------

// File: rtl/gb_sound_pkg.sv
// Shared constants and types for the pulse-channel timing blocks.
package gb_sound_pkg;
  localparam int FREQ_W            = 11;
  localparam int FREQ_MAX          = 2047;
  localparam int PERIOD_BASE       = 2048;
  localparam int SWEEP_ZERO_RELOAD = 8;

  typedef logic [FREQ_W-1:0] freq_t;
endpackage

// File: rtl/sweep_unit.sv
// Channel-1 frequency sweep: sweep timer, shadow frequency, enable and the
// calculate/overflow logic. Reports a write strobe, the new value and overflow.
module sweep_unit
  import gb_sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger_i,
  input  freq_t      freq_in_i,
  input  logic [2:0] period_i,
  input  logic       negate_i,
  input  logic [2:0] shift_i,
  input  logic       tick_i,
  input  logic       off_i,
  output logic       wr_o,
  output freq_t      new_freq_o,
  output logic       ovf_o
);
  localparam logic [FREQ_W:0] LIMIT = (FREQ_W+1)'(FREQ_MAX);

  // One extra bit holds the overflow; max sum is 4094, so it never wraps.
  function automatic logic [FREQ_W:0] sweep_calc(input freq_t f, input logic neg,
                                                 input logic [2:0] sh);
    logic [FREQ_W:0] base;
    logic [FREQ_W:0] delta;
    base  = {1'b0, f};
    delta = base >> sh;
    return neg ? (base - delta) : (base + delta);
  endfunction

  freq_t           shadow_q, shadow_d;
  logic [3:0]      stimer_q, stimer_d;
  logic            en_q, en_d;
  logic [3:0]      reload;
  logic [FREQ_W:0] new1, new2, trig_calc;

  assign reload     = (period_i == 3'd0) ? 4'(SWEEP_ZERO_RELOAD) : {1'b0, period_i};
  assign new1       = sweep_calc(shadow_q, negate_i, shift_i);
  assign new2       = sweep_calc(new1[FREQ_W-1:0], negate_i, shift_i);
  assign trig_calc  = sweep_calc(freq_in_i, negate_i, shift_i);
  assign new_freq_o = new1[FREQ_W-1:0];

  always_comb begin
    stimer_d = stimer_q;
    shadow_d = shadow_q;
    en_d     = en_q;
    wr_o     = 1'b0;
    ovf_o    = 1'b0;
    if (trigger_i) begin
      stimer_d = reload;
      shadow_d = freq_in_i;
      en_d     = (period_i != 3'd0) || (shift_i != 3'd0);
      ovf_o    = (shift_i != 3'd0) && (trig_calc > LIMIT);
    end else if (tick_i && (stimer_q != 4'd0)) begin
      if (stimer_q == 4'd1) begin
        stimer_d = reload;
        if (en_q && (period_i != 3'd0)) begin
          if (new1 > LIMIT) begin
            ovf_o = 1'b1;
          end else if (shift_i != 3'd0) begin
            wr_o  = !off_i;
            ovf_o = (new2 > LIMIT);
            if (!off_i) shadow_d = new1[FREQ_W-1:0];
          end
        end
      end else begin
        stimer_d = stimer_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stimer_q <= '0;
      shadow_q <= '0;
      en_q     <= 1'b0;
    end else begin
      stimer_q <= stimer_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
    end
  end
endmodule

// File: rtl/square_freq_sweep.sv
// Pulse channel 1 timing: prescaler plus period timer producing the duty
// sequencer step strobe, with the frequency sweep unit alongside.
module square_freq_sweep
  import gb_sound_pkg::*;
#(
  parameter int PRESCALE = 4
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic        freq_wr,
  input  logic [10:0] freq_in,
  input  logic [2:0]  sweep_period,
  input  logic        sweep_negate,
  input  logic [2:0]  sweep_shift,
  input  logic        sweep_tick,
  output logic        step,
  output logic [10:0] freq_out,
  output logic        channel_off
);
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [11:0]    BASE     = 12'(PERIOD_BASE);

  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   timer_q, timer_d;
  freq_t         freq_q, freq_d;
  logic          off_q, off_d;
  logic          step_q, step_d;
  logic          pre_tick;
  logic          sw_wr, sw_ovf;
  freq_t         sw_freq;

  sweep_unit u_sweep (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger_i  (trigger),
    .freq_in_i  (freq_in),
    .period_i   (sweep_period),
    .negate_i   (sweep_negate),
    .shift_i    (sweep_shift),
    .tick_i     (sweep_tick),
    .off_i      (off_q),
    .wr_o       (sw_wr),
    .new_freq_o (sw_freq),
    .ovf_o      (sw_ovf)
  );

  always_comb begin
    pre_d    = pre_q;
    timer_d  = timer_q;
    freq_d   = freq_q;
    off_d    = off_q | sw_ovf;
    step_d   = 1'b0;
    pre_tick = !trigger && !off_q && (pre_q == PRE_LAST);
    if (trigger) begin
      pre_d   = '0;
      timer_d = BASE - {1'b0, freq_in};
      freq_d  = freq_in;
      off_d   = sw_ovf;
    end else begin
      // A direct write beats a same-cycle sweep result on the active frequency.
      if (freq_wr)    freq_d = freq_in;
      else if (sw_wr) freq_d = sw_freq;
      if (!off_q) pre_d = pre_tick ? '0 : pre_q + 1'b1;
      if (pre_tick) begin
        if (timer_q == 12'd1) begin
          timer_d = BASE - {1'b0, freq_q};
          step_d  = !off_d;
        end else begin
          timer_d = timer_q - 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      timer_q <= '0;
      freq_q  <= '0;
      off_q   <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      timer_q <= timer_d;
      freq_q  <= freq_d;
      off_q   <= off_d;
      step_q  <= step_d;
    end
  end

  assign step        = step_q;
  assign freq_out    = freq_q;
  assign channel_off = off_q;
endmodule

// File: tb/tb_square_freq_sweep.sv
// Directed bench for square_freq_sweep with PRESCALE=4 and hand-computed expectations.
module tb_square_freq_sweep;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger;
  logic        freq_wr;
  logic [10:0] freq_in;
  logic [2:0]  sweep_period;
  logic        sweep_negate;
  logic [2:0]  sweep_shift;
  logic        sweep_tick;
  logic        step;
  logic [10:0] freq_out;
  logic        channel_off;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  square_freq_sweep #(.PRESCALE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .freq_wr      (freq_wr),
    .freq_in      (freq_in),
    .sweep_period (sweep_period),
    .sweep_negate (sweep_negate),
    .sweep_shift  (sweep_shift),
    .sweep_tick   (sweep_tick),
    .step         (step),
    .freq_out     (freq_out),
    .channel_off  (channel_off)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic [10:0] f, input logic [2:0] per,
                      input logic [2:0] sh, input logic neg);
    freq_in      = f;
    sweep_period = per;
    sweep_shift  = sh;
    sweep_negate = neg;
    trigger      = 1'b1;
    cyc();
    trigger      = 1'b0;
  endtask

  task automatic sweep_pulse();
    sweep_tick = 1'b1;
    cyc();
    sweep_tick = 1'b0;
  endtask

  // Cycles until step is seen; bound+1 is returned on timeout.
  task automatic wait_step(input int bound, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n <= bound);
  endtask

  task automatic count_steps(input int len, output int n);
    n = 0;
    repeat (len) begin
      cyc();
      if (step) n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; trigger = 1'b0; freq_wr = 1'b0; freq_in = '0;
    sweep_period = '0; sweep_negate = 1'b0; sweep_shift = '0; sweep_tick = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_step", step, 0);
    check("rst_freq", freq_out, 0);
    check("rst_off", channel_off, 1);
    rst_n = 1'b1;
    sweep_period = 3'd1; sweep_shift = 3'd1;
    sweep_pulse();
    check("post_rst_off", channel_off, 1);
    check("post_rst_freq", freq_out, 0);
    check("post_rst_step", step, 0);

    // f=2047: step every 4 clocks, one clock wide.
    trig(11'd2047, 3'd0, 3'd0, 1'b0);
    check("t1_off", channel_off, 0);
    check("t1_freq", freq_out, 2047);
    check("t1_step0", step, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("t1_step_k%0d", k), step, (k % 4 == 0) ? 1 : 0);
    end

    // f=0: first period 8192; a mid-count write lands at the next reload.
    trig(11'd0, 3'd0, 3'd0, 1'b0);
    repeat (100) cyc();
    freq_in = 11'd2046;
    freq_wr = 1'b1;
    cyc();
    freq_wr = 1'b0;
    check("t2_freq_wr", freq_out, 2046);
    wait_step(9000, n);
    check("t2_first_period", n, 8192 - 101);
    wait_step(100, n);
    check("t2_second_period", n, 8);

    // f=1024 add shift 1: one sweep gives 1536, second check overflows.
    trig(11'd1024, 3'd1, 3'd1, 1'b0);
    check("t3_off_trig", channel_off, 0);
    wait_step(5000, n);
    check("t3_running", n, 4096);
    sweep_pulse();
    check("t3_freq", freq_out, 1536);
    check("t3_off", channel_off, 1);
    count_steps(5000, n);
    check("t3_no_steps", n, 0);

    // f=1400 add shift 1 overflows immediately on trigger.
    trig(11'd1400, 3'd0, 3'd1, 1'b0);
    check("t4_off", channel_off, 1);
    check("t4_freq", freq_out, 1400);
    count_steps(6000, n);
    check("t4_no_steps", n, 0);

    // f=1024 period 2 shift 2 subtract; then a freq_wr colliding with a sweep write.
    trig(11'd1024, 3'd2, 3'd2, 1'b1);
    check("t5_off_trig", channel_off, 0);
    repeat (2) cyc();
    sweep_pulse();
    check("t5_tick1_freq", freq_out, 1024);
    repeat (2) cyc();
    sweep_pulse();
    check("t5_tick2_freq", freq_out, 768);
    check("t5_tick2_off", channel_off, 0);
    sweep_pulse();
    check("t5_tick3_freq", freq_out, 768);
    freq_in = 11'd100;
    freq_wr = 1'b1;
    sweep_pulse();
    freq_wr = 1'b0;
    check("t5_collide_freq", freq_out, 100);
    sweep_pulse();
    check("t5_tick5_freq", freq_out, 100);
    sweep_pulse();
    check("t5_shadow_kept", freq_out, 432);

    // f=2040 free-running, async reset mid-operation, then restart.
    trig(11'd2040, 3'd0, 3'd0, 1'b0);
    wait_step(100, n);
    check("t6_period", n, 32);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_step", step, 0);
    check("t6_async_freq", freq_out, 0);
    check("t6_async_off", channel_off, 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_rel_off", channel_off, 1);
    check("t6_rel_step", step, 0);
    trig(11'd2047, 3'd0, 3'd0, 1'b0);
    wait_step(20, n);
    check("t6_resume", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
